uart_core: RTL and testbench



---
 rtl/uart_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// Full-duplex UART, fixed frame (start, NR_BITS data LSB first, optional parity, STOP_BITS stops).
// TX line changes the cycle after accept; uart_tx_dr holds off new words until the last stop cycle.
module uart_core #(
    parameter int    CLK_FREQ  = 50000000,
    parameter int    BAUD_RATE = 115200,
    parameter int    NR_BITS   = 8,
    parameter string PARITY    = "NONE",
    parameter int    STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [NR_BITS-1:0] uart_rx_d,
    output logic               uart_rx_dv,
    output logic               parity_ok,
    input  logic [NR_BITS-1:0] uart_tx_d,
    input  logic               uart_tx_dv,
    output logic               uart_tx_dr,
    input  logic               uart_rx,
    output logic               uart_tx
);

    localparam int DIV      = CLK_FREQ / BAUD_RATE;
    localparam int HALF     = DIV / 2;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CW       = $clog2(STOP_LEN + 1);
    localparam bit PAR_EN   = (PARITY != "NONE");
    localparam bit PAR_ODD  = (PARITY == "ODD");

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t          tx_state_q, tx_state_d;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [3:0]         tx_bit_q, tx_bit_d;
    logic [NR_BITS-1:0] tx_shift_q, tx_shift_d;
    logic               tx_par_q, tx_par_d;
    logic               tx_line_q, tx_line_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (uart_tx_dv) begin
                    tx_shift_d = uart_tx_d;
                    tx_par_d   = PAR_ODD ? ~^uart_tx_d : ^uart_tx_d;
                    tx_line_d  = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CW'(DIV - 1)) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CW'(DIV - 1)) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'(NR_BITS - 1)) begin
                        tx_line_d  = PAR_EN ? tx_par_q : 1'b1;
                        tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = {1'b0, tx_shift_q[NR_BITS-1:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_PARITY: begin
                if (tx_cnt_q == CW'(DIV - 1)) begin
                    tx_cnt_d   = '0;
                    tx_line_d  = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                // Leave one cycle early: IDLE doubles as the final stop cycle so a
                // word accepted there starts its start bit with no idle gap.
                if (tx_cnt_q == CW'(STOP_LEN - 2)) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign uart_tx_dr = (tx_state_q == TX_IDLE);
    assign uart_tx    = tx_line_q;

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;

    logic               rx_meta_q, rx_sync_q;
    rx_state_t          rx_state_q, rx_state_d;
    logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [3:0]         rx_bit_q, rx_bit_d;
    logic [NR_BITS-1:0] rx_shift_q, rx_shift_d;
    logic               rx_par_q, rx_par_d;
    logic [NR_BITS-1:0] rx_data_q, rx_data_d;
    logic               rx_ok_q, rx_ok_d;
    logic               rx_dv_q, rx_dv_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_ok_q    <= 1'b0;
            rx_dv_q    <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_ok_q    <= rx_ok_d;
            rx_dv_q    <= rx_dv_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_ok_d    = rx_ok_q;
        rx_dv_d    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CW'(HALF - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CW'(DIV - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[NR_BITS-1:1]};
                    if (rx_bit_q == 4'(NR_BITS - 1)) begin
                        rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == CW'(DIV - 1)) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CW'(DIV - 1)) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_ok_d    = !PAR_EN ||
                                     (rx_par_q == (PAR_ODD ? ~^rx_shift_q : ^rx_shift_q));
                        rx_dv_d    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_WAIT: begin
                // Framing error: a line stuck low must not look like a new start bit.
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign uart_rx_d  = rx_data_q;
    assign uart_rx_dv = rx_dv_q;
    assign parity_ok  = rx_ok_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: default 8N1 instance plus an EVEN-parity receiver.
module tb_uart_core;

    localparam int DIV   = 434;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_d, tx_d;
    logic       rx_dv, par_ok, tx_dv, tx_dr, tx_line, rx_line;
    logic       rx_drv, loop_en;
    logic [7:0] rx_d_p;
    logic       rx_dv_p, par_ok_p, tx_dr_p, tx_line_p, rx_p;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] cap_d[$];
    logic       cap_p[$];
    logic [7:0] cap_d_p[$];
    logic       cap_p_p[$];

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx_line : rx_drv;

    uart_core u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx_d  (rx_d),
        .uart_rx_dv (rx_dv),
        .parity_ok  (par_ok),
        .uart_tx_d  (tx_d),
        .uart_tx_dv (tx_dv),
        .uart_tx_dr (tx_dr),
        .uart_rx    (rx_line),
        .uart_tx    (tx_line)
    );

    uart_core #(.PARITY("EVEN")) u_par (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx_d  (rx_d_p),
        .uart_rx_dv (rx_dv_p),
        .parity_ok  (par_ok_p),
        .uart_tx_d  (8'h00),
        .uart_tx_dv (1'b0),
        .uart_tx_dr (tx_dr_p),
        .uart_rx    (rx_p),
        .uart_tx    (tx_line_p)
    );

    always @(negedge clk) begin
        if (rx_dv) begin
            cap_d.push_back(rx_d);
            cap_p.push_back(par_ok);
        end
        if (rx_dv_p) begin
            cap_d_p.push_back(rx_d_p);
            cap_p_p.push_back(par_ok_p);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Captured word i as {parity_ok, data}; 0xDEAD when fewer words arrived.
    function automatic logic [31:0] got_word(input int i, input bit par_dut);
        if (par_dut)
            return (i < cap_d_p.size()) ? {23'd0, cap_p_p[i], cap_d_p[i]} : 32'hDEAD;
        return (i < cap_d.size()) ? {23'd0, cap_p[i], cap_d[i]} : 32'hDEAD;
    endfunction

    task automatic clear_caps();
        cap_d.delete();
        cap_p.delete();
        cap_d_p.delete();
        cap_p_p.delete();
    endtask

    task automatic send_word(input logic [7:0] w, input string tag);
        int n = 0;
        @(negedge clk);
        while (!tx_dr && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, {31'd0, tx_dr}, 32'd1);
        tx_d  = w;
        tx_dv = 1'b1;
        @(posedge clk);
        #1 tx_dv = 1'b0;
    endtask

    // Sends w and checks every line sample of the frame plus the ready handshake timing.
    task automatic check_frame(input logic [7:0] w, input string tag);
        logic [9:0] bits;
        int errs[10];
        int dr_cycle = 0;
        bits = {1'b1, w, 1'b0};
        for (int j = 0; j < 10; j++) errs[j] = 0;
        send_word(w, tag);
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, "_dr_drop"}, {31'd0, tx_dr}, 32'd0);
            if (tx_line !== bits[(c-1)/DIV]) errs[(c-1)/DIV]++;
            if (dr_cycle == 0 && tx_dr) dr_cycle = c;
        end
        for (int j = 0; j < 10; j++)
            check($sformatf("%s_bit%0d_errs", tag, j), errs[j], 32'd0);
        check({tag, "_dr_return_cycle"}, dr_cycle, FRAME);
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n, input bit to_par);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (to_par) rx_p = bits[i];
            else        rx_drv = bits[i];
            repeat (DIV) @(negedge clk);
        end
        rx_p   = 1'b1;
        rx_drv = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        tx_d    = 8'h00;
        tx_dv   = 1'b0;
        rx_drv  = 1'b1;
        rx_p    = 1'b1;
        loop_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx",    {31'd0, tx_line}, 32'd1);
        check("rst_dr",    {31'd0, tx_dr},   32'd1);
        check("rst_rx_dv", {31'd0, rx_dv},   32'd0);
        check("rst_rx_d",  {24'd0, rx_d},    32'd0);
        check("rst_par",   {31'd0, par_ok},  32'd0);
        check("rst_p_tx",  {30'd0, tx_dr_p, tx_line_p}, 32'd3);

        // 0x55 on the line: alternating 0/1 bits of one bit period each
        check_frame(8'h55, "tx55");

        // loopback, two words back to back
        clear_caps();
        loop_en = 1'b1;
        send_word(8'hA3, "lb0");
        send_word(8'h00, "lb1");
        repeat (FRAME + 1000) @(negedge clk);
        check("lb_count", cap_d.size(), 32'd2);
        check("lb_word0", got_word(0, 1'b0), 32'h1A3);
        check("lb_word1", got_word(1, 1'b0), 32'h100);
        loop_en = 1'b0;

        // even parity: 0x07 has three ones, so correct parity bit is 1
        clear_caps();
        drive_bits({5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b1);
        repeat (300) @(negedge clk);
        check("par_good_count", cap_d_p.size(), 32'd1);
        check("par_good_word", got_word(0, 1'b1), 32'h107);
        clear_caps();
        drive_bits({5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b1);
        repeat (300) @(negedge clk);
        check("par_bad_count", cap_d_p.size(), 32'd1);
        check("par_bad_word", got_word(0, 1'b1), 32'h007);

        // 100-cycle low glitch is shorter than half a bit
        clear_caps();
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (100) @(negedge clk);
        rx_drv = 1'b1;
        repeat (1000) @(negedge clk);
        check("glitch_no_dv", cap_d.size(), 32'd0);
        drive_bits({6'd0, 1'b1, 8'h3C, 1'b0}, 10, 1'b0);
        repeat (300) @(negedge clk);
        check("glitch_next_count", cap_d.size(), 32'd1);
        check("glitch_next_word", got_word(0, 1'b0), 32'h13C);

        // framing error: stop bit low
        clear_caps();
        drive_bits({6'd0, 1'b0, 8'hFF, 1'b0}, 10, 1'b0);
        repeat (1000) @(negedge clk);
        check("frm_no_dv", cap_d.size(), 32'd0);
        check("frm_rx_d_held", {24'd0, rx_d}, 32'h3C);
        drive_bits({6'd0, 1'b1, 8'h5A, 1'b0}, 10, 1'b0);
        repeat (300) @(negedge clk);
        check("frm_rearm_word", got_word(0, 1'b0), 32'h15A);

        // reset during data bit 3 of 0x96 (bit 3 is 0)
        send_word(8'h96, "rst_mid");
        repeat (4 * DIV + 200) @(negedge clk);
        check("rst_mid_line_pre", {31'd0, tx_line}, 32'd0);
        check("rst_mid_dr_pre",   {31'd0, tx_dr},   32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_line", {31'd0, tx_line}, 32'd1);
        check("rst_mid_dr",   {31'd0, tx_dr},   32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_frame(8'hC5, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
